// File: rtl/div_sequencer.sv
// Keypad front end for the 4-bit BCD divider: builds two operands in 00..15,
// launches the divider, waits a fixed latency and holds quotient/remainder.
module div_sequencer #(
    parameter int unsigned DIV_LAT = 6,
    parameter int unsigned CNT_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       div_start,
    output logic [7:0] div_a_bcd,
    output logic [7:0] div_b_bcd,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r,
    output logic [3:0] result_q,
    output logic [3:0] result_r,
    output logic       result_valid,
    output logic       error,
    output logic       busy,
    output logic       entry_sel
);

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_LAUNCH,
        S_WAIT,
        S_SHOW,
        S_ERR
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);

    state_e           state_q, state_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [3:0]       rq_q, rq_d;
    logic [3:0]       rr_q, rr_d;
    logic             rv_q, rv_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       is_digit, is_next, is_equals, is_clear;
    logic [3:0] b_bin;

    // A second digit is only accepted when it keeps the operand at 15 or below.
    function automatic logic [7:0] push_digit(input logic [7:0] op, input logic [3:0] d);
        logic [7:0] res;
        res = op;
        if (op == 8'h00)
            res = {4'h0, d};
        else if (op[7:4] == 4'h0 && op[3:0] == 4'h1 && d <= 4'd5)
            res = {4'h1, d};
        return res;
    endfunction

    assign is_digit  = key_valid && (key_code <= 4'd9);
    assign is_next   = key_valid && (key_code == 4'hA);
    assign is_equals = key_valid && (key_code == 4'hB);
    assign is_clear  = key_valid && (key_code == 4'hC);
    assign b_bin     = 4'(b_q[7:4] * 4'd10) + b_q[3:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        rv_d    = rv_q;
        err_d   = err_q;
        start_d = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            S_ENTER_A: begin
                if (is_digit)
                    a_d = push_digit(a_q, key_code);
                else if (is_next)
                    state_d = S_ENTER_B;
            end
            S_ENTER_B: begin
                if (is_digit) begin
                    b_d = push_digit(b_q, key_code);
                end else if (is_next) begin
                    state_d = S_ENTER_A;
                end else if (is_equals) begin
                    if (b_bin == 4'd0) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LAUNCH;
                        start_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    rq_d    = div_q;
                    rr_d    = div_r;
                    rv_d    = 1'b1;
                    state_d = S_SHOW;
                end
            end
            S_SHOW, S_ERR: begin
                if (is_digit) begin
                    a_d     = {4'h0, key_code};
                    b_d     = '0;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_ENTER_A;
                end else if (is_equals && state_q == S_SHOW) begin
                    rv_d    = 1'b0;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_ENTER_A;
        endcase

        // CLEAR overrides whatever the state logic decided, including an in-flight divide.
        if (is_clear) begin
            state_d = S_ENTER_A;
            a_d     = '0;
            b_d     = '0;
            rq_d    = '0;
            rr_d    = '0;
            rv_d    = 1'b0;
            err_d   = 1'b0;
            start_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    assign div_start    = start_q;
    assign div_a_bcd    = a_q;
    assign div_b_bcd    = b_q;
    assign result_q     = rq_q;
    assign result_r     = rr_q;
    assign result_valid = rv_q;
    assign error        = err_q;
    assign busy         = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign entry_sel    = (state_q == S_ENTER_B);

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Front-end controller for the 4-bit BCD divider datapath (`operacion`). It collects dividend and divisor digits from a keypad event stream and keeps each operand in the 0..15 range. It checks for divide-by-zero, issues a one-cycle start pulse to the divider, waits a fixed latency, then latches and holds quotient/remainder for the display stage.

Parameters:
DIV_LAT, 6, cycles after the div_start pulse at which div_q/div_r are sampled (divider needs 4; margin included)
CNT_W, 3, width of latency counter; must satisfy 2**CNT_W > DIV_LAT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
key_valid  in  1  one-cycle pulse, key_code valid
key_code  in  4  0-9 digit, 4'hA NEXT, 4'hB EQUALS, 4'hC CLEAR, others ignored
div_start  out  1  one-cycle start pulse to divider
div_a_bcd  out  8  {tens,units} dividend to divider
div_b_bcd  out  8  {tens,units} divisor to divider
div_q  in  4  divider quotient
div_r  in  4  divider remainder
result_q  out  4  latched quotient
result_r  out  4  latched remainder
result_valid  out  1  high while a result is held
error  out  1  high after EQUALS with divisor 0
busy  out  1  high in LAUNCH and WAIT
entry_sel  out  1  0 = editing A, 1 = editing B (for display)

Behaviour:
- Reset is synchronous: rst high at a clk edge forces state ENTER_A, div_a_bcd=div_b_bcd=8'h00, result_q=result_r=0, result_valid=0, error=0, div_start=0, counter=0. rst has priority over every event, including mid-WAIT; the divider result in flight is discarded.
- The key_valid gate applies to digit and key events only; keys that arrive without key_valid are not processed.
- States: ENTER_A, ENTER_B, LAUNCH, WAIT, SHOW, ERR.
- Digit entry (ENTER_A edits A, ENTER_B edits B); the operand is {t,u}:
  - If t==0 and u==0: u <= d (first digit).
  - Otherwise, if t==0 and u<=1 and {u,d} <= 15: t <= u, u <= d.
  - Otherwise the digit is rejected; the operand is unchanged. Only BCD 00..15 is ever produced.
- Operand binary value is t*10+u, computed with a 4-bit result.
- ENTER_A: NEXT -> ENTER_B. EQUALS is ignored.
- ENTER_B: EQUALS with binary(B)==0 -> ERR, error<=1. EQUALS otherwise -> LAUNCH. NEXT -> ENTER_A, with A kept.
- LAUNCH (1 cycle): div_start=1, operands stable; then -> WAIT and the counter is cleared.
- WAIT: counter increments every cycle. When the counter reaches DIV_LAT-1, result_q<=div_q, result_r<=div_r, result_valid<=1 on that edge; then -> SHOW.
  - Capture edge is exactly DIV_LAT clock edges after the edge that sampled div_start=1.
- div_a_bcd/div_b_bcd are held constant through LAUNCH and WAIT.
- SHOW: the result is held.
  - Digit key: clear A, B and result_valid, then apply the digit as the first digit of A; -> ENTER_A.
  - EQUALS: relaunch with the same operands (-> LAUNCH, result_valid<=0).
  - NEXT is ignored.
- ERR: only CLEAR or a digit key leaves it. A digit key behaves as in SHOW and error<=0.
- CLEAR in any state: same effect as reset except rst-only priority. In LAUNCH/WAIT it aborts the operation, no capture occurs, and the next state is ENTER_A.
- Keys other than CLEAR during LAUNCH/WAIT are dropped; there is no queuing.
- entry_sel=1 only in ENTER_B; otherwise 0. busy=1 in LAUNCH and WAIT only.
- All outputs are registered except busy and entry_sel, which decode state.

Test Plan:
- Reset then keys 1,5,NEXT,6,EQUALS: div_a_bcd=8'h15, div_b_bcd=8'h06, one div_start pulse, busy for 1+DIV_LAT cycles; then result_q=2, result_r=3, result_valid=1.
- Keys 9,NEXT,3,EQUALS; in SHOW press EQUALS again: second div_start pulse, result_valid drops for 1+DIV_LAT cycles, then Q=3 R=0.
- Keys 1,2,NEXT,0,EQUALS: no div_start, error=1, state ERR. Then key 4: error=0, div_a_bcd=8'h04, entry_sel=0.
- Digit bounds: keys 1,6 -> A stays 8'h01; keys 1,5,7 -> A stays 8'h15; keys 0,0,7 -> A=8'h07.
- Keys 4,NEXT,2,EQUALS, then CLEAR 2 cycles after div_start: no capture, result_valid stays 0, operands 8'h00, state ENTER_A.
- Start an operation (8/3), then assert rst during WAIT: all outputs return to reset values on the next edge; a later 8/3 run gives Q=2 R=2.
